// File: rtl/playback_sequencer_pkg.sv
// rtl/playback_sequencer_pkg.sv - shared encodings and defaults for the playback sequencer
package playback_sequencer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_BIT_DEF  = 8;

  // Song entry layout: {note[7:3], len[2:0]}, note 0 is a rest
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int LEN_MSB  = 2;
  localparam int LEN_LSB  = 0;
  localparam int NOTE_W   = NOTE_MSB - NOTE_LSB + 1;

  typedef enum logic [1:0] {
    MODE_AUTOPLAY = 2'b00,
    MODE_LEARNING = 2'b01,
    MODE_GAME     = 2'b10,
    MODE_OTHER    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_PTR,
    S_FETCH,
    S_WAIT_DATA,
    S_PLAY,
    S_HOLD,
    S_GAP,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/playback_sequencer_prescaler.sv
// rtl/playback_sequencer_prescaler.sv - beat tick divider with enable and synchronous clear
module beat_prescaler
  import playback_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - fetches song entries and times each note in beat ticks
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH_BIT  = DEPTH_BIT_DEF,
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned GAP_TICKS  = 1,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  stop_i,
  input  logic                  key_hit_i,
  input  logic [NOTE_W-1:0]     key_note_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_output_ready_i,
  input  logic [DEPTH_BIT-1:0]  mem_duration_i,
  output logic                  mem_read_en_o,
  output logic                  mem_read_rst_o,
  output logic [NOTE_W-1:0]     note_out_o,
  output logic                  note_valid_o,
  output logic [DEPTH_BIT-1:0]  note_index_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  seq_state_e           state_q;
  logic [NOTE_W-1:0]    note_q;
  logic [3:0]           beats_q;
  logic [GW-1:0]        gap_q;
  logic [TW-1:0]        timer_q;
  logic [DEPTH_BIT-1:0] idx_q;
  logic                 err_q, done_q, rd_en_q, rd_rst_q, nv_q;

  mode_e                mode;
  logic                 tick, presc_en, presc_clr, abort, last_entry, gap_over;
  logic [DEPTH_BIT:0]   idx_inc;

  assign mode       = mode_e'(mode_i);
  assign abort      = (state_q != S_IDLE) && (stop_i || mode == MODE_OTHER);
  assign idx_inc    = {1'b0, idx_q} + (DEPTH_BIT + 1)'(1);
  assign last_entry = (idx_inc == {1'b0, mem_duration_i});
  assign gap_over   = (GAP_TICKS == 0) || (tick && gap_q == GW'(GAP_TICKS - 1));

  // Holding the prescaler clear through WAIT_DATA means every note starts on a fresh beat
  assign presc_en  = (state_q == S_PLAY || state_q == S_GAP) && !pause_i;
  assign presc_clr = (state_q == S_WAIT_DATA);

  beat_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      note_q   <= '0;
      beats_q  <= '0;
      gap_q    <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_rst_q <= 1'b0;
      nv_q     <= 1'b0;
    end else begin
      rd_en_q  <= 1'b0;
      rd_rst_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort) begin
        state_q  <= S_IDLE;
        rd_rst_q <= 1'b1;
        nv_q     <= 1'b0;
        note_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && mode != MODE_OTHER) begin
              err_q    <= 1'b0;
              idx_q    <= '0;
              rd_rst_q <= 1'b1;
              state_q  <= S_RST_PTR;
            end
          end
          S_RST_PTR: begin
            if (mem_duration_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            timer_q <= '0;
            state_q <= S_WAIT_DATA;
          end
          S_WAIT_DATA: begin
            if (mem_output_ready_i) begin
              note_q  <= mem_data_i[NOTE_MSB:NOTE_LSB];
              beats_q <= {1'b0, mem_data_i[LEN_MSB:LEN_LSB]} + 4'd1;
              nv_q    <= (mem_data_i[NOTE_MSB:NOTE_LSB] != '0);
              state_q <= S_PLAY;
            end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_PLAY: begin
            if (tick) begin
              if (beats_q == 4'd1) begin
                if (mode == MODE_LEARNING && note_q != '0) begin
                  state_q <= S_HOLD;
                end else begin
                  nv_q    <= 1'b0;
                  note_q  <= '0;
                  gap_q   <= '0;
                  state_q <= S_GAP;
                end
              end else begin
                beats_q <= beats_q - 4'd1;
              end
            end
          end
          S_HOLD: begin
            if (key_hit_i && key_note_i == note_q) begin
              nv_q    <= 1'b0;
              note_q  <= '0;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_over) begin
              if (last_entry) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_inc[DEPTH_BIT-1:0];
                rd_en_q <= 1'b1;
                state_q <= S_FETCH;
              end
            end else if (tick) begin
              gap_q <= gap_q + GW'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_read_en_o  = rd_en_q;
  assign mem_read_rst_o = rd_rst_q;
  assign note_out_o     = note_q;
  assign note_valid_o   = nv_q && !pause_i;
  assign note_index_o   = idx_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
